// File: rtl/trace_stack.sv
// trace_stack: LIFO assignment trail for the DPLL controller with a live decision-level count.
// Top of stack is visible combinationally; push, pop and replace each take effect at one clock edge.
`ifndef MAX_VARS
`define MAX_VARS 16
`endif
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 4
`endif

module trace_stack #(
    parameter int DEPTH    = `MAX_VARS,
    parameter int VAR_BITS = `MAX_VARS_BITS,
    parameter int CNT_BITS = $clog2(DEPTH + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clear,
    input  logic                push,
    input  logic [VAR_BITS-1:0] var_in,
    input  logic                val_in,
    input  logic                type_in,
    input  logic                pop,
    output logic [VAR_BITS-1:0] var_out,
    output logic                val_out,
    output logic                type_out,
    output logic                empty,
    output logic                full,
    output logic [CNT_BITS-1:0] count,
    output logic [CNT_BITS-1:0] decision_level,
    output logic                overflow,
    output logic                underflow
);

    localparam int IDX_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [VAR_BITS-1:0] vidx;
        logic                val;
        logic                typ;
    } entry_t;

    entry_t              mem_q [DEPTH];
    logic [CNT_BITS-1:0] count_q, count_d;
    logic [CNT_BITS-1:0] level_q, level_d;
    logic                ovf_q, ovf_d;
    logic                udf_q, udf_d;

    logic                wr_en;
    logic [IDX_BITS-1:0] wr_idx;
    logic [IDX_BITS-1:0] top_idx;
    entry_t              wr_data;
    entry_t              top;
    logic                is_empty;
    logic                is_full;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CNT_BITS'(DEPTH));
    assign top_idx  = is_empty ? '0 : IDX_BITS'(count_q - CNT_BITS'(1));
    assign top      = mem_q[top_idx];
    assign wr_data  = '{vidx: var_in, val: val_in, typ: type_in};

    // NOTE: always_comb uses blocking '=' with a default for every target first, so no latch is inferred.
    always_comb begin
        count_d = count_q;
        level_d = level_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        wr_en   = 1'b0;
        wr_idx  = IDX_BITS'(count_q);

        if (clear) begin
            count_d = '0;
            level_d = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else if (push && pop && !is_empty) begin
            // Replace in place: legal even when full, count unchanged.
            wr_en   = 1'b1;
            wr_idx  = top_idx;
            level_d = level_q - CNT_BITS'(top.typ) + CNT_BITS'(type_in);
        end else if (push) begin
            if (pop) begin
                udf_d = 1'b1;
            end
            if (!is_full) begin
                wr_en   = 1'b1;
                count_d = count_q + CNT_BITS'(1);
                level_d = level_q + CNT_BITS'(type_in);
            end else begin
                ovf_d = 1'b1;
            end
        end else if (pop) begin
            if (is_empty) begin
                udf_d = 1'b1;
            end else begin
                count_d = count_q - CNT_BITS'(1);
                level_d = level_q - CNT_BITS'(top.typ);
            end
        end
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // NOTE: the entry array is deliberately not reset; count alone defines which entries are valid.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    assign var_out        = is_empty ? '0 : top.vidx;
    assign val_out        = is_empty ? 1'b0 : top.val;
    assign type_out       = is_empty ? 1'b0 : top.typ;
    assign empty          = is_empty;
    assign full           = is_full;
    assign count          = count_q;
    assign decision_level = level_q;
    assign overflow       = ovf_q;
    assign underflow      = udf_q;

endmodule

// File: doc/trace_stack.md
# trace_stack

Assignment trail (LIFO) for the DPLL controller. The controller pushes every variable assignment, tagged as decision or implication; on conflict it pops entries to backtrack. The block answers the controller's `push_trace`/`pop_trace`/`var_in_trace`/`val_in_trace`/`type_in_trace` requests and returns `var_out_trace`/`val_out_trace`/`type_out_trace`/`empty_trace`. It also maintains a live decision-level count, so the controller can detect "no decisions left" and declare UNSAT.

## Interface
Parameters:
- DEPTH, default `MAX_VARS: entry capacity. Each variable is on the trail at most once.
- VAR_BITS, default `MAX_VARS_BITS: width of a variable index.
- CNT_BITS, default $clog2(DEPTH+1): width of the count and level outputs.

Ports:
- clock  in  1  sole clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high.
- clear  in  1  synchronous flush to empty; also clears the error flags.
- push  in  1  write {var_in, val_in, type_in} as the new top.
- var_in  in  VAR_BITS  variable index to push.
- val_in  in  1  assigned value.
- type_in  in  1  entry type: 1 = decision, 0 = implied.
- pop  in  1  remove the top entry.
- var_out  out  VAR_BITS  top entry variable; 0 when empty.
- val_out  out  1  top entry value; 0 when empty.
- type_out  out  1  top entry type; 0 when empty.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- count  out  CNT_BITS  number of entries.
- decision_level  out  CNT_BITS  number of stacked entries with type = 1.
- overflow  out  1  sticky; set by a dropped push.
- underflow  out  1  sticky; set by an ignored pop.

## Operation
Storage:
- Storage is a DEPTH-entry array of {var, val, type} plus a stack pointer `count`.
- The top entry is at index count-1.
- The array is not reset; its contents are don't-care above the top.

Priority per cycle is reset > clear > push/pop.

Command decode when clear = 0:
- push only, not full: mem[count] ← in; count+1; decision_level + type_in.
- push only, full: entry dropped; state unchanged; overflow ← 1.
- pop only, not empty: count−1; decision_level − type of the old top.
- pop only, empty: ignored; underflow ← 1.
- push + pop, not empty: replace in place, so mem[count-1] ← in and count is unchanged. decision_level changes by type_in − old top type. This case is legal when full.
- push + pop, empty: behaves as push only, and underflow ← 1.
- neither: hold.

clear:
- count ← 0, decision_level ← 0, overflow ← 0, underflow ← 0.
- push and pop in the same cycle are ignored.

Output rules:
- var_out, val_out and type_out are combinational functions of registered state only; there is no input-to-output path. They are forced to 0 when empty.
- empty and full derive from count.
- Invariant: decision_level ≤ count.
- Arithmetic: count and decision_level never wrap. The overflow and underflow cases above are the only boundary behaviour.

## Timing
- Reset, asynchronous: count = 0, decision_level = 0, overflow = 0, underflow = 0. Consequently empty = 1, full = 0, and var_out = val_out = type_out = 0, all within the reset assertion, with no clock needed. Reset asserted mid-operation discards all entries immediately.
- Push latency is 1 cycle: an entry pushed at posedge N appears on the *_out ports after posedge N. count and decision_level update at the same edge.
- Pop latency is 1 cycle: after posedge N the outputs show the new top, or zeros if the stack is now empty.
- Throughput is one push, pop or replace per cycle, sustained back-to-back with no bubbles.
- The controller samples the outputs in the same cycle it decides to pop. Combinational top visibility therefore lets backtracking read type_out, pop, and read the next entry on successive cycles.
- The sticky flags set at the offending posedge and stay set until clear or reset.

## Test plan
- Reset: assert reset mid-cycle with no clock edge. Expect empty = 1, count = 0, decision_level = 0, var_out = 0, overflow = underflow = 0.
- Push / pop ordering: push (3,1,D), (5,0,I), (7,1,D). Expect count = 3, decision_level = 2, top = (7,1,1). Pop twice: expect tops (5,0,0) then (3,1,1), with decision_level 1 after both pops.
- Replace: with stack [(3,1,D),(5,0,I)], assert push (9,1,D) + pop together. Expect count = 2, top = (9,1,1), decision_level = 2.
- Full / overflow: with DEPTH = 4, push 5 entries. Expect full = 1 after the 4th, the 5th dropped, overflow = 1, and top still the 4th entry. Then push+pop while full: the replace succeeds and count = 4.
- Empty / underflow: pop on empty → underflow = 1 and count = 0. Push+pop on empty → entry stored, count = 1, underflow = 1.
- Clear and reset mid-operation: with 3 entries, both flags set, assert clear together with push. Expect count = 0, flags = 0, and the push ignored. Repeat with async reset asserted between edges: zeros appear immediately.
